pixel_streamer: RTL

- Transmit end of the pixel/select interface consumed by the colour accumulator.
- Fetches NUM_PIX pixels from the image memory (1-cycle read latency) and presents each on pixel_out with a single-cycle sel strobe.
- Strobes are spaced by a fixed period; a clear pulse precedes each frame so the downstream accumulator starts from zero.
- Signals completion with a one-cycle done pulse.

---
 rtl/pixel_streamer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pixel_streamer.sv
// rtl/pixel_streamer.sv - fetches a frame of pixels and strobes each one to the colour accumulator
// Define PIX_STREAMER_CHECKSUM_EN to add the chk_sum running-sum output.
module pixel_streamer #(
    parameter int PIX_W   = 8,
    parameter int ADDR_W  = 15,
    parameter int NUM_PIX = 4096,
    parameter int GAP     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [PIX_W-1:0]  mem_data,
    output logic              clr,
    output logic [PIX_W-1:0]  pixel_out,
    output logic              sel,
    output logic              busy,
    output logic              done
`ifdef PIX_STREAMER_CHECKSUM_EN
    ,
    output logic [22:0]       chk_sum
`endif
);

    // Gap counter only ever holds GAP-1 down to 0.
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIX - 1);
    localparam logic [GW-1:0]     GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_READ,
        S_LATCH,
        S_EMIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [GW-1:0]     gap_cnt;

    // Outputs are registered, so each is set on the edge that enters the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            gap_cnt   <= '0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            clr       <= 1'b0;
            pixel_out <= '0;
            sel       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            clr    <= 1'b0;
            mem_rd <= 1'b0;
            sel    <= 1'b0;
            done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_CLEAR;
                        clr   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    idx      <= '0;
                    mem_addr <= '0;
                    mem_rd   <= 1'b1;
                    state    <= S_READ;
                end
                S_READ: begin
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    pixel_out <= mem_data;
                    sel       <= 1'b1;
                    state     <= S_EMIT;
                end
                S_EMIT: begin
                    if (idx == LAST_IDX) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else if (GAP == 0) begin
                        idx      <= idx + 1'b1;
                        mem_addr <= idx + 1'b1;
                        mem_rd   <= 1'b1;
                        state    <= S_READ;
                    end else begin
                        gap_cnt <= GAP_LOAD;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        idx      <= idx + 1'b1;
                        mem_addr <= idx + 1'b1;
                        mem_rd   <= 1'b1;
                        state    <= S_READ;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIX_STREAMER_CHECKSUM_EN
    // pixel_out is stable throughout EMIT, so the sum picks it up on the EMIT edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_sum <= '0;
        end else if (state == S_CLEAR) begin
            chk_sum <= '0;
        end else if (state == S_EMIT) begin
            chk_sum <= chk_sum + 23'(pixel_out);
        end
    end
`endif

endmodule
